// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: line framing constants and frame FSM states shared by the
// transmitter and the sequence-detector side of the pattern line.
package serial_frame_tx_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP1 = 3'd3,
        STOP2 = 3'd4
    } state_t;
    localparam logic START_BIT  = 1'b1;
    localparam int   STOP_BITS  = 2;
    localparam logic IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// serial_bit_timer: down-counter that strobes bit_end in the last cycle of each
// BIT_CYC-cycle line bit while run is high; reloads whenever run is low.
module serial_bit_timer #(
    parameter int BIT_CYC = 1
) (
    input  logic CLK,
    input  logic CLR,
    input  logic run,
    output logic bit_end
);
    localparam int CW = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] TOP = CW'(BIT_CYC - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) cnt <= '0;
        else cnt <= (!run || cnt == '0) ? TOP : cnt - CW'(1);
    assign bit_end = run && cnt == '0;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames a parallel word as start bit 1, DATA_W payload bits and
// two stop bits 0 0 on a registered serial line, with a valid/ready load handshake.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BIT_CYC   = 1,
    parameter bit MSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              x_out,
    output logic              busy,
    output logic              done
);
    localparam int BW = $clog2(DATA_W);
    state_t state, state_d;
    logic [DATA_W-1:0] sh, sh_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic bit_end, accept, last_bit, x_d;
    serial_bit_timer #(.BIT_CYC(BIT_CYC)) u_timer (
        .CLK(CLK),
        .CLR(CLR),
        .run(busy),
        .bit_end(bit_end)
    );
    assign busy     = state != IDLE;
    assign done     = state == STOP2 && bit_end;
    assign ready    = state == IDLE || done;
    assign accept   = load && ready;
    assign last_bit = bit_cnt == BW'(DATA_W - 1);
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = STOP1;
            STOP1:   if (bit_end) state_d = STOP2;
            STOP2:   if (bit_end) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
        sh_d = accept ? din : (state == DATA && bit_end) ? (MSB_FIRST ? sh << 1 : sh >> 1) : sh;
        bit_cnt_d = (state == DATA && bit_end) ? (last_bit ? '0 : bit_cnt + BW'(1)) : bit_cnt;
        // line level is registered, so it is derived from the state being entered
        x_d = state_d == START ? START_BIT
            : state_d == DATA ? (MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0])
            : IDLE_LEVEL;
    end
    always_ff @(posedge CLK or negedge CLR)
        if (!CLR) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            x_out   <= IDLE_LEVEL;
        end else begin
            state   <= state_d;
            sh      <= sh_d;
            bit_cnt <= bit_cnt_d;
            x_out   <= x_d;
        end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: three transmitter configurations checked cycle by cycle against
// a queue of expected line bits built from the frame format.
module tb_serial_frame_tx;
    typedef struct packed {logic x; logic last;} fb_t;
    logic CLK = 0;
    logic CLR = 1;
    logic [7:0] din [3];
    logic load [3];
    logic ready [3];
    logic x_out [3];
    logic busy [3];
    logic done [3];
    fb_t q [3][$];
    fb_t cur [3];
    logic cur_v [3];
    int acc_cnt [3];
    int n_chk = 0;
    int n_fail = 0;
    always #5 CLK = ~CLK;
    serial_frame_tx #(.DATA_W(8), .BIT_CYC(1), .MSB_FIRST(1)) u0 (
        .CLK(CLK), .CLR(CLR), .din(din[0]), .load(load[0]),
        .ready(ready[0]), .x_out(x_out[0]), .busy(busy[0]), .done(done[0]));
    serial_frame_tx #(.DATA_W(8), .BIT_CYC(1), .MSB_FIRST(0)) u1 (
        .CLK(CLK), .CLR(CLR), .din(din[1]), .load(load[1]),
        .ready(ready[1]), .x_out(x_out[1]), .busy(busy[1]), .done(done[1]));
    serial_frame_tx #(.DATA_W(8), .BIT_CYC(4), .MSB_FIRST(1)) u2 (
        .CLK(CLK), .CLR(CLR), .din(din[2]), .load(load[2]),
        .ready(ready[2]), .x_out(x_out[2]), .busy(busy[2]), .done(done[2]));
    function automatic int bc(int k);
        return k == 2 ? 4 : 1;
    endfunction
    task automatic push_frame(int k, logic [7:0] w);
        for (int i = 0; i < 11; i++) begin
            logic v;
            v = i == 0 ? 1'b1 : i <= 8 ? w[k == 1 ? i - 1 : 8 - i] : 1'b0;
            for (int r = 0; r < bc(k); r++) q[k].push_back('{x: v, last: (i == 10 && r == bc(k) - 1)});
        end
    endtask
    task automatic chk(string tag, int k, logic obs, logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d at %0t: observed %b expected %b", tag, k, $time, obs, exp);
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("x_out", k, x_out[k], cur_v[k] ? cur[k].x : 1'b0);
            chk("busy", k, busy[k], cur_v[k]);
            chk("done", k, done[k], cur_v[k] && cur[k].last);
            chk("ready", k, ready[k], q[k].size() == 0);
        end
    endtask
    task automatic cycle();
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            if (CLR && load[k] && q[k].size() == 0) begin
                push_frame(k, din[k]);
                acc_cnt[k]++;
            end
            cur_v[k] = q[k].size() != 0;
            if (cur_v[k]) cur[k] = q[k].pop_front();
        end
        @(negedge CLK);
        check_all();
    endtask
    task automatic set_load(logic v);
        for (int k = 0; k < 3; k++) load[k] = v;
    endtask
    task automatic pulse(logic [7:0] w);
        for (int k = 0; k < 3; k++) din[k] = w;
        set_load(1);
        cycle();
        set_load(0);
    endtask
    initial begin
        for (int k = 0; k < 3; k++) begin
            load[k] = 0;
            din[k] = 0;
            cur_v[k] = 0;
            cur[k] = '0;
            acc_cnt[k] = 0;
        end
        #1 CLR = 0;
        #1 check_all();
        @(negedge CLK);
        CLR = 1;
        din = '{8'hA5, 8'h01, 8'hF0};
        set_load(1);
        cycle();
        set_load(0);
        repeat (50) cycle();
        for (int k = 0; k < 3; k++) acc_cnt[k] = 0;
        din = '{8'hFF, 8'hFF, 8'hFF};
        set_load(1);
        repeat (110) begin
            cycle();
            for (int k = 0; k < 3; k++) begin
                if (acc_cnt[k] >= 1) din[k] = 8'h00;
                if (acc_cnt[k] >= 2) load[k] = 0;
            end
        end
        set_load(0);
        repeat (10) cycle();
        pulse(8'hA5);
        repeat (4) cycle();
        pulse(8'h3C);
        repeat (50) cycle();
        repeat (400) begin
            for (int k = 0; k < 3; k++) begin
                load[k] = $urandom_range(0, 3) == 0;
                din[k] = 8'($urandom);
            end
            cycle();
        end
        set_load(0);
        repeat (50) cycle();
        pulse(8'hA5);
        repeat (4) cycle();
        #1 CLR = 0;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            cur_v[k] = 0;
        end
        #1 check_all();
        cycle();
        CLR = 1;
        pulse(8'h81);
        repeat (50) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
